// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, port owner encoding and access sizes.
package mmix_defs;

    typedef enum logic [1:0] {
        A_IDLE,
        A_BUSY,
        A_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_E    = 2'd2
    } owner_t;

    localparam logic [1:0] DS_BYTE  = 2'd0;
    localparam logic [1:0] DS_WYDE  = 2'd1;
    localparam logic [1:0] DS_TETRA = 2'd2;
    localparam logic [1:0] DS_OCTA  = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: latched request strobes out, completion and read data back.
interface mem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic [AW-1:0] mem_address;
    logic [1:0]    mem_datasize;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_done;

    modport master (
        output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_done
    );

    modport slave (
        input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_done
    );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// BUSY-phase watchdog for mem_arbiter: down-counter reloaded on grant, expires on its last enabled cycle.
// Instantiated only when MMIX_MEM_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CW'(TIMEOUT_CYCLES);
        end else if (clear) begin
            count <= CW'(TIMEOUT_CYCLES);
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // count == 1 marks the TIMEOUT_CYCLES-th enabled cycle since the reload
    assign expire = enable && (count == CW'(1));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single CPU memory port between fetch (read-only) and exec (read/write), exec first.
// Optional BUSY watchdog abort is enabled by defining MMIX_MEM_TIMEOUT_EN.
//   state  | meaning
//   A_IDLE | sample requests, grant exec before fetch, latch the access
//   A_BUSY | strobe held on memory until mem_done (or watchdog expiry)
//   A_RESP | one-cycle done pulse to the owner, requests ignored
module mem_arbiter
    import mmix_defs::*;
#(
    parameter int AW             = 64,
    parameter int DW             = 64,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_address,
    input  logic [1:0]    f_datasize,
    output logic          f_done,
    input  logic          e_req_read,
    input  logic          e_req_write,
    input  logic [AW-1:0] e_address,
    input  logic [1:0]    e_datasize,
    input  logic [DW-1:0] e_writedata,
    output logic          e_done,
    output logic [DW-1:0] rdata,
    output logic [1:0]    owner,
    output logic          timeout_err,
    mem_arbiter_if.master mem
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t    state, state_next;
    owner_t        owner_q;
    logic          grant_e, grant_f, finish, abort, wd_expire;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          rd_q, wr_q;
    logic [DW-1:0] wdata_q, rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= A_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_e    = 1'b0;
        grant_f    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            A_IDLE: begin
                if (e_req_read || e_req_write) begin
                    grant_e    = 1'b1;
                    state_next = A_BUSY;
                end else if (f_req) begin
                    grant_f    = 1'b1;
                    state_next = A_BUSY;
                end
            end
            A_BUSY: begin
                // a completion in the same cycle as expiry is honoured, not aborted
                if (mem.mem_done) begin
                    finish     = 1'b1;
                    state_next = A_RESP;
                end else if (wd_expire) begin
                    abort      = 1'b1;
                    state_next = A_RESP;
                end
            end
            A_RESP:  state_next = A_IDLE;
            default: state_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            owner_q <= OWN_NONE;
        end else begin
            if (grant_e) begin
                addr_q  <= e_address;
                size_q  <= e_datasize;
                wdata_q <= e_writedata;
                wr_q    <= e_req_write;
                rd_q    <= ~e_req_write;
                owner_q <= OWN_E;
            end else if (grant_f) begin
                addr_q  <= f_address;
                size_q  <= f_datasize;
                rd_q    <= 1'b1;
                wr_q    <= 1'b0;
                owner_q <= OWN_F;
            end
            if (finish || abort) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end
            if (finish && rd_q) rdata_q <= mem.mem_readdata;
            else if (abort)     rdata_q <= '1;
            if (state == A_RESP) owner_q <= OWN_NONE;
        end
    end

`ifdef MMIX_MEM_TIMEOUT_EN
    logic timed_out;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant_e | grant_f),
        .enable (state == A_BUSY),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                timed_out <= 1'b0;
        else if (abort)           timed_out <= 1'b1;
        else if (state == A_RESP) timed_out <= 1'b0;
    end

    assign timeout_err = (state == A_RESP) && timed_out;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign mem.mem_address   = addr_q;
    assign mem.mem_datasize  = size_q;
    assign mem.mem_read      = rd_q;
    assign mem.mem_write     = wr_q;
    assign mem.mem_writedata = wdata_q;

    assign rdata  = rdata_q;
    assign owner  = owner_q;
    assign f_done = (state == A_RESP) && (owner_q == OWN_F);
    assign e_done = (state == A_RESP) && (owner_q == OWN_E);

    a_exec_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(state == A_IDLE && e_req_read && e_req_write))
        else $warning("mem_arbiter: exec read and write requested together, write taken");
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized sessions against a queue-based model.
module tb_mem_arbiter;
    import mmix_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, e_req_read, e_req_write;
    logic [63:0] f_address, e_address, e_writedata;
    logic [1:0]  f_datasize, e_datasize;
    logic        f_done, e_done, timeout_err;
    logic [63:0] rdata;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(64), .DW(64)) bus ();

    mem_arbiter #(.AW(64), .DW(64), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_address(f_address), .f_datasize(f_datasize), .f_done(f_done),
        .e_req_read(e_req_read), .e_req_write(e_req_write), .e_address(e_address),
        .e_datasize(e_datasize), .e_writedata(e_writedata), .e_done(e_done),
        .rdata(rdata), .owner(owner), .timeout_err(timeout_err), .mem(bus)
    );

    typedef struct {
        int          who;
        int          own;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        rd;
        logic        wr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        to;
    } rec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          mem_lat = 2;
    bit          mem_hang = 1'b0;
    int          addr_unstable = 0;
    int          both_strobes = 0;
    logic [63:0] mem_array [logic [63:0]];
    logic [63:0] model_mem [logic [63:0]];
    logic [63:0] model_rdata;
    rec_t        recs[$];

    function automatic logic [63:0] mem_init(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return mem_init(a);
    endfunction

    // memory responder: completes an access mem_lat strobe cycles after it starts
    initial begin
        int k;
        logic [63:0] a0;
        k = 0;
        a0 = '0;
        bus.mem_done = 1'b0;
        bus.mem_readdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_done = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
                k++;
                if (k == 1) a0 = bus.mem_address;
                else if (bus.mem_address !== a0) addr_unstable++;
                if (bus.mem_read && bus.mem_write) both_strobes++;
                if (!mem_hang && k >= mem_lat && k < 100000) begin
                    bus.mem_done = 1'b1;
                    if (bus.mem_write) begin
                        mem_array[bus.mem_address] = bus.mem_writedata;
                        bus.mem_readdata = 64'hBAD0_BAD0_BAD0_BAD0;
                    end else if (mem_array.exists(bus.mem_address)) begin
                        bus.mem_readdata = mem_array[bus.mem_address];
                    end else begin
                        bus.mem_readdata = mem_init(bus.mem_address);
                    end
                    k = 100000;
                end
            end else begin
                k = 0;
            end
        end
    end

    // completion monitor: snapshot of the bus while strobed, pushed on each done pulse
    initial begin
        rec_t snap;
        snap.who = 0; snap.own = 0; snap.addr = '0; snap.size = '0; snap.rd = 0;
        snap.wr = 0; snap.wdata = '0; snap.rdata = '0; snap.to = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_read || bus.mem_write) begin
                snap.own   = int'(owner);
                snap.addr  = bus.mem_address;
                snap.size  = bus.mem_datasize;
                snap.rd    = bus.mem_read;
                snap.wr    = bus.mem_write;
                snap.wdata = bus.mem_writedata;
            end
            if (f_done || e_done) begin
                snap.who   = (f_done ? 1 : 0) + (e_done ? 2 : 0);
                snap.rdata = rdata;
                snap.to    = timeout_err;
                recs.push_back(snap);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_session(input logic fr, input logic er, input logic ew,
                               input logic [63:0] fa, input logic [63:0] ea,
                               input logic [1:0] fs, input logic [1:0] es,
                               input logic [63:0] wd, input int lat, output bit finished);
        mem_lat = lat;
        f_address = fa; f_datasize = fs; e_address = ea; e_datasize = es; e_writedata = wd;
        f_req = fr; e_req_read = er; e_req_write = ew;
        finished = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (f_done) f_req = 1'b0;
            if (e_done) begin e_req_read = 1'b0; e_req_write = 1'b0; end
            if (!f_req && !e_req_read && !e_req_write) begin finished = 1'b1; break; end
        end
        f_req = 1'b0; e_req_read = 1'b0; e_req_write = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
        n_checks++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b want 0", bus.mem_read); end
        n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
        n_checks++; if (f_done !== 1'b0 || e_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got f=%b e=%b want 0 0", f_done, e_done); end
        n_checks++; if (bus.mem_address !== 64'h0) begin n_fail++; $display("FAIL reset_mem_address: got %h want 0", bus.mem_address); end
        n_checks++; if (bus.mem_writedata !== 64'h0) begin n_fail++; $display("FAIL reset_mem_writedata: got %h want 0", bus.mem_writedata); end
        n_checks++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        reset = 1'b0;
        tick();
        n_checks++; if (bus.mem_read !== 1'b0 || owner !== 2'd0) begin n_fail++; $display("FAIL idle_no_req: got read=%b owner=%0d want 0 0", bus.mem_read, owner); end
    endtask

    task automatic test_fetch_read();
        mem_array[64'h100] = 64'hDEADBEEF_00000001;
        model_mem[64'h100] = 64'hDEADBEEF_00000001;
        mem_lat = 2;
        f_address = 64'h100; f_datasize = DS_OCTA; f_req = 1'b1;
        tick();
        n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL fetch_strobe: got r=%b w=%b want 1 0", bus.mem_read, bus.mem_write); end
        n_checks++; if (owner !== 2'd1) begin n_fail++; $display("FAIL fetch_owner_busy: got %0d want 1", owner); end
        n_checks++; if (bus.mem_address !== 64'h100 || bus.mem_datasize !== DS_OCTA) begin n_fail++; $display("FAIL fetch_bus: got %h/%0d want 100/3", bus.mem_address, bus.mem_datasize); end
        tick();
        n_checks++; if (bus.mem_read !== 1'b1 || f_done !== 1'b0) begin n_fail++; $display("FAIL fetch_hold: got r=%b done=%b want 1 0", bus.mem_read, f_done); end
        tick();
        n_checks++; if (f_done !== 1'b1 || e_done !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got f=%b e=%b want 1 0", f_done, e_done); end
        n_checks++; if (rdata !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL fetch_rdata: got %h want deadbeef00000001", rdata); end
        n_checks++; if (bus.mem_read !== 1'b0 || owner !== 2'd1) begin n_fail++; $display("FAIL fetch_resp: got r=%b owner=%0d want 0 1", bus.mem_read, owner); end
        f_req = 1'b0;
        model_rdata = 64'hDEADBEEF_00000001;
        tick();
        n_checks++; if (f_done !== 1'b0 || owner !== 2'd0) begin n_fail++; $display("FAIL fetch_after: got done=%b owner=%0d want 0 0", f_done, owner); end
    endtask

    task automatic test_priority();
        bit fin;
        recs.delete();
        run_session(1'b1, 1'b1, 1'b0, 64'h100, 64'h200, DS_OCTA, DS_TETRA, 64'h0, 3, fin);
        n_checks++; if (!fin) begin n_fail++; $display("FAIL prio_finish: got timeout want both served"); end
        n_checks++; if (recs.size() != 2) begin n_fail++; $display("FAIL prio_count: got %0d want 2", recs.size()); end
        if (recs.size() == 2) begin
            n_checks++; if (recs[0].who != 2 || recs[0].addr !== 64'h200) begin n_fail++; $display("FAIL prio_first: got who=%0d addr=%h want 2 200", recs[0].who, recs[0].addr); end
            n_checks++; if (recs[0].rdata !== model_read(64'h200)) begin n_fail++; $display("FAIL prio_first_rdata: got %h want %h", recs[0].rdata, model_read(64'h200)); end
            n_checks++; if (recs[1].who != 1 || recs[1].addr !== 64'h100) begin n_fail++; $display("FAIL prio_second: got who=%0d addr=%h want 1 100", recs[1].who, recs[1].addr); end
            n_checks++; if (recs[1].rdata !== model_read(64'h100)) begin n_fail++; $display("FAIL prio_second_rdata: got %h want %h", recs[1].rdata, model_read(64'h100)); end
        end
        model_rdata = model_read(64'h100);
    endtask

    task automatic test_write_stable();
        int ecount;
        int unstable0;
        logic [63:0] rd_at_done, stored;
        ecount = 0; unstable0 = addr_unstable; rd_at_done = '0;
        mem_lat = 4;
        e_address = 64'h300; e_writedata = 64'h55; e_datasize = DS_BYTE; e_req_write = 1'b1;
        tick();
        n_checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL wr_strobe: got r=%b w=%b want 0 1", bus.mem_read, bus.mem_write); end
        n_checks++; if (bus.mem_address !== 64'h300 || bus.mem_writedata !== 64'h55) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 300/55", bus.mem_address, bus.mem_writedata); end
        e_address = 64'h999; e_writedata = 64'hAA;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (e_done) begin ecount++; rd_at_done = rdata; e_req_write = 1'b0; end
        end
        stored = mem_array.exists(64'h300) ? mem_array[64'h300] : 64'hx;
        n_checks++; if (ecount != 1) begin n_fail++; $display("FAIL wr_done_count: got %0d want 1", ecount); end
        n_checks++; if (addr_unstable != unstable0) begin n_fail++; $display("FAIL wr_addr_stable: got %0d changes want 0", addr_unstable - unstable0); end
        n_checks++; if (stored !== 64'h55) begin n_fail++; $display("FAIL wr_mem_data: got %h want 55", stored); end
        n_checks++; if (rd_at_done !== model_rdata) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", rd_at_done, model_rdata); end
        model_mem[64'h300] = 64'h55;
    endtask

    task automatic test_rw_conflict();
        int ecount;
        logic [63:0] rd_at_done;
        ecount = 0; rd_at_done = '0;
        mem_lat = 1;
        e_address = 64'h400; e_writedata = 64'h77; e_datasize = DS_TETRA;
        e_req_read = 1'b1; e_req_write = 1'b1;
        tick();
        n_checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL rw_write_wins: got r=%b w=%b want 0 1", bus.mem_read, bus.mem_write); end
        n_checks++; if (owner !== 2'd2) begin n_fail++; $display("FAIL rw_owner: got %0d want 2", owner); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (e_done) begin ecount++; rd_at_done = rdata; e_req_read = 1'b0; e_req_write = 1'b0; end
        end
        n_checks++; if (ecount != 1) begin n_fail++; $display("FAIL rw_done_count: got %0d want 1", ecount); end
        n_checks++; if (rd_at_done !== model_rdata) begin n_fail++; $display("FAIL rw_rdata_kept: got %h want %h", rd_at_done, model_rdata); end
        model_mem[64'h400] = 64'h77;
    endtask

    task automatic test_reset_mid();
        int n0;
        bit fin;
        mem_hang = 1'b1;
        n0 = recs.size();
        f_address = 64'h500; f_datasize = DS_WYDE; f_req = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got r=%b want 1", bus.mem_read); end
        #3 reset = 1'b1;
        #1;
        n_checks++; if (bus.mem_read !== 1'b0 || owner !== 2'd0) begin n_fail++; $display("FAIL rst_mid_async: got r=%b owner=%0d want 0 0", bus.mem_read, owner); end
        n_checks++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
        f_req = 1'b0;
        repeat (2) tick();
        reset = 1'b0; mem_hang = 1'b0; model_rdata = '0;
        repeat (3) tick();
        n_checks++; if (recs.size() != n0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", recs.size() - n0); end
        recs.delete();
        run_session(1'b1, 1'b0, 1'b0, 64'h508, 64'h0, DS_OCTA, DS_BYTE, 64'h0, 3, fin);
        n_checks++; if (!fin || recs.size() != 1) begin n_fail++; $display("FAIL rst_mid_recover: got fin=%0d pulses=%0d want 1 1", fin, recs.size()); end
        if (recs.size() == 1) begin
            n_checks++; if (recs[0].who != 1 || recs[0].rdata !== model_read(64'h508)) begin n_fail++; $display("FAIL rst_mid_recover_data: got who=%0d %h want 1 %h", recs[0].who, recs[0].rdata, model_read(64'h508)); end
        end
        model_rdata = model_read(64'h508);
    endtask

    task automatic test_timeout();
        int hi;
`ifdef MMIX_MEM_TIMEOUT_EN
        bit seen;
        hi = 0; seen = 1'b0;
        mem_hang = 1'b1;
        f_address = 64'h600; f_datasize = DS_OCTA; f_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.mem_read) hi++;
            else begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL to_abort: got strobe still high want dropped"); end
        n_checks++; if (hi != 8) begin n_fail++; $display("FAIL to_busy_cycles: got %0d want 8", hi); end
        n_checks++; if (f_done !== 1'b1 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_done: got done=%b err=%b want 1 1", f_done, timeout_err); end
        n_checks++; if (rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL to_rdata: got %h want all ones", rdata); end
        f_req = 1'b0; mem_hang = 1'b0;
        tick();
        n_checks++; if (f_done !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_after: got done=%b err=%b want 0 0", f_done, timeout_err); end
        model_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        int dn;
        bit got;
        logic to_seen;
        logic [63:0] cap;
        hi = 0; dn = 0; got = 1'b0; to_seen = 1'b0; cap = '0;
        mem_hang = 1'b1;
        f_address = 64'h600; f_datasize = DS_OCTA; f_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.mem_read) hi++;
            if (f_done || timeout_err) dn++;
        end
        n_checks++; if (hi != 30) begin n_fail++; $display("FAIL wait_forever_strobe: got %0d want 30", hi); end
        n_checks++; if (dn != 0) begin n_fail++; $display("FAIL wait_forever_no_done: got %0d want 0", dn); end
        mem_hang = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (f_done) begin got = 1'b1; cap = rdata; to_seen = timeout_err; f_req = 1'b0; break; end
        end
        f_req = 1'b0;
        tick();
        n_checks++; if (!got) begin n_fail++; $display("FAIL wait_forever_release: got no done want done"); end
        n_checks++; if (cap !== model_read(64'h600) || to_seen !== 1'b0) begin n_fail++; $display("FAIL wait_forever_data: got %h err=%b want %h 0", cap, to_seen, model_read(64'h600)); end
        model_rdata = model_read(64'h600);
`endif
    endtask

    task automatic test_random();
        rec_t exp[$];
        rec_t r;
        int mode, lat;
        logic fr, er, ew;
        logic [63:0] fa, ea, wd;
        logic [1:0] fs, es;
        bit fin;
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 4);
            fr = (mode == 0) || (mode >= 3);
            er = (mode == 1) || (mode == 3);
            ew = (mode == 2) || (mode == 4);
            fa = {$urandom, $urandom}; ea = {$urandom, $urandom}; wd = {$urandom, $urandom};
            fs = 2'($urandom_range(0, 3)); es = 2'($urandom_range(0, 3));
            lat = $urandom_range(1, 5);
            exp.delete();
            if (er || ew) begin
                r.who = 2; r.own = 2; r.addr = ea; r.size = es; r.rd = !ew; r.wr = ew; r.wdata = wd; r.to = 1'b0;
                if (ew) model_mem[ea] = wd;
                else    model_rdata = model_read(ea);
                r.rdata = model_rdata;
                exp.push_back(r);
            end
            if (fr) begin
                r.who = 1; r.own = 1; r.addr = fa; r.size = fs; r.rd = 1'b1; r.wr = 1'b0; r.wdata = '0; r.to = 1'b0;
                model_rdata = model_read(fa);
                r.rdata = model_rdata;
                exp.push_back(r);
            end
            recs.delete();
            run_session(fr, er, ew, fa, ea, fs, es, wd, lat, fin);
            n_checks++; if (!fin) begin n_fail++; $display("FAIL rnd_finish[%0d]: got timeout want all served", i); end
            n_checks++; if (recs.size() != exp.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, recs.size(), exp.size()); end
            for (int j = 0; j < exp.size() && j < recs.size(); j++) begin
                n_checks++; if (recs[j].who != exp[j].who || recs[j].own != exp[j].own) begin n_fail++; $display("FAIL rnd_order[%0d.%0d]: got who=%0d own=%0d want %0d", i, j, recs[j].who, recs[j].own, exp[j].who); end
                n_checks++; if (recs[j].addr !== exp[j].addr || recs[j].size !== exp[j].size) begin n_fail++; $display("FAIL rnd_bus[%0d.%0d]: got %h/%0d want %h/%0d", i, j, recs[j].addr, recs[j].size, exp[j].addr, exp[j].size); end
                n_checks++; if (recs[j].rd !== exp[j].rd || recs[j].wr !== exp[j].wr) begin n_fail++; $display("FAIL rnd_dir[%0d.%0d]: got r=%b w=%b want r=%b w=%b", i, j, recs[j].rd, recs[j].wr, exp[j].rd, exp[j].wr); end
                n_checks++; if (recs[j].rdata !== exp[j].rdata || recs[j].to !== 1'b0) begin n_fail++; $display("FAIL rnd_rdata[%0d.%0d]: got %h err=%b want %h 0", i, j, recs[j].rdata, recs[j].to, exp[j].rdata); end
                if (exp[j].wr) begin
                    n_checks++; if (recs[j].wdata !== exp[j].wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d.%0d]: got %h want %h", i, j, recs[j].wdata, exp[j].wdata); end
                end
            end
        end
        n_checks++; if (both_strobes != 0) begin n_fail++; $display("FAIL both_strobes: got %0d cycles want 0", both_strobes); end
        n_checks++; if (addr_unstable != 0) begin n_fail++; $display("FAIL addr_stability: got %0d changes want 0", addr_unstable); end
    endtask

    initial begin
        reset = 1'b1;
        f_req = 1'b0; e_req_read = 1'b0; e_req_write = 1'b0;
        f_address = '0; e_address = '0; e_writedata = '0;
        f_datasize = '0; e_datasize = '0;
        model_rdata = '0;
        test_reset();
        test_fetch_read();
        test_priority();
        test_write_stable();
        test_rw_conflict();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
